// File: rtl/ex_cell_bist_pkg.sv
// Shared types and LFSR helpers for the multi-bit flop cell BIST controller.
package ex_cell_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // 16-bit Galois step; the pattern is taken from the value before stepping.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/ex_cell_bist_dly.sv
// Latency-matching delay line carrying {valid, pattern} alongside the cell under test.
module ex_cell_bist_dly #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Shift register stages; stage 0 takes the newly issued pattern.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      data_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/ex_cell_bist.sv
// BIST controller: drives LFSR patterns into a flop cell, checks its latency-aligned
// response, and reports a saturating mismatch count with pass/fail.
module ex_cell_bist
  import ex_cell_bist_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter int          DUT_LAT = 1,
  parameter logic [15:0] SEED    = DEFAULT_SEED,
  parameter int          ERRW    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [15:0]      RUN_LEN,
  output logic [WIDTH-1:0] STIM,
  input  logic [WIDTH-1:0] RESP,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERRW-1:0]  ERR_CNT
);

  localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      remain_q, remain_d;
  logic [2:0]       drain_q, drain_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic             stim_vld_q, stim_vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERRW-1:0]  err_q, err_d;

  logic             head_vld_s;
  logic [WIDTH-1:0] head_data_s;
  logic             mismatch_s;

  ex_cell_bist_dly #(.WIDTH(WIDTH), .DEPTH(DUT_LAT)) u_dly (
    .clk_i  (CLK),
    .rst_i  (RST),
    .vld_i  (stim_vld_q),
    .data_i (stim_q),
    .vld_o  (head_vld_s),
    .data_o (head_data_s)
  );

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      remain_q   <= 16'd0;
      drain_q    <= 3'd0;
      stim_q     <= '0;
      stim_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      remain_q   <= remain_d;
      drain_q    <= drain_d;
      stim_q     <= stim_d;
      stim_vld_q <= stim_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
    end
  end

  // Next-state, pattern issue and compare logic.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    remain_d   = remain_q;
    drain_d    = drain_q;
    stim_d     = stim_q;
    stim_vld_d = stim_vld_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;

    mismatch_s = head_vld_s && (RESP != head_data_s);
    if (mismatch_s && (err_q != ERR_MAX)) begin
      err_d = err_q + ERRW'(1);
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          err_d  = '0;
          lfsr_d = SEED;
          if (RUN_LEN == 16'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d    = ST_RUN;
            stim_d     = SEED[WIDTH-1:0];
            stim_vld_d = 1'b1;
            lfsr_d     = lfsr_next(SEED);
            remain_d   = RUN_LEN - 16'd1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            pass_d     = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (remain_q == 16'd0) begin
          state_d    = ST_DRAIN;
          stim_d     = '0;
          stim_vld_d = 1'b0;
          drain_d    = 3'(DUT_LAT - 1);
        end else begin
          stim_d   = lfsr_q[WIDTH-1:0];
          lfsr_d   = lfsr_next(lfsr_q);
          remain_d = remain_q - 16'd1;
        end
      end
      ST_DRAIN: begin
        // The last in-flight pattern is compared on this same edge, so use err_d.
        if (drain_q == 3'd0) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign STIM    = stim_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PASS    = pass_q;
  assign ERR_CNT = err_q;

endmodule

// File: tb/tb_ex_cell_bist.sv
// Directed bench: four controller instances share stimulus and see different DUT models.
module tb_ex_cell_bist;

  logic        clk, rst, start, force_b2;
  logic [15:0] run_len;
  int          n_vec, n_err;

  logic [3:0] exp_pat [4] = '{4'h1, 4'h0, 4'h8, 4'hC};

  logic [3:0]  stim_a, resp_a, ff_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] err_a;
  logic [3:0]  stim_s, resp_s, ff_s;
  logic        busy_s, done_s, pass_s;
  logic [1:0]  err_s;
  logic [3:0]  stim_b, resp_b, ch1_b, ch2_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] err_b;
  logic [3:0]  stim_c, resp_c, ch1_c, ch2_c;
  logic        busy_c, done_c, pass_c;
  logic [15:0] err_c;

  ex_cell_bist #(.WIDTH(4), .DUT_LAT(1), .SEED(16'hACE1), .ERRW(16)) dut_a (
    .CLK(clk), .RST(rst), .START(start), .RUN_LEN(run_len), .STIM(stim_a), .RESP(resp_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a));
  ex_cell_bist #(.WIDTH(4), .DUT_LAT(1), .SEED(16'hACE1), .ERRW(2)) dut_s (
    .CLK(clk), .RST(rst), .START(start), .RUN_LEN(run_len), .STIM(stim_s), .RESP(resp_s),
    .BUSY(busy_s), .DONE(done_s), .PASS(pass_s), .ERR_CNT(err_s));
  ex_cell_bist #(.WIDTH(4), .DUT_LAT(2), .SEED(16'hACE1), .ERRW(16)) dut_b (
    .CLK(clk), .RST(rst), .START(start), .RUN_LEN(run_len), .STIM(stim_b), .RESP(resp_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b));
  ex_cell_bist #(.WIDTH(4), .DUT_LAT(1), .SEED(16'hACE1), .ERRW(16)) dut_c (
    .CLK(clk), .RST(rst), .START(start), .RUN_LEN(run_len), .STIM(stim_c), .RESP(resp_c),
    .BUSY(busy_c), .DONE(done_c), .PASS(pass_c), .ERR_CNT(err_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell models: one dffm4 per single-latency instance, two chained dfxtp for b and c.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_a <= 4'h0; ff_s <= 4'h0;
      ch1_b <= 4'h0; ch2_b <= 4'h0; ch1_c <= 4'h0; ch2_c <= 4'h0;
    end else begin
      ff_a <= stim_a; ff_s <= stim_s;
      ch1_b <= stim_b; ch2_b <= ch1_b; ch1_c <= stim_c; ch2_c <= ch1_c;
    end
  end

  assign resp_a = force_b2 ? (ff_a & 4'b1011) : ff_a;
  assign resp_s = ~ff_s;
  assign resp_b = ch2_b;
  assign resp_c = ch2_c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request a run before edge 0; returns in cycle 1.
  task automatic launch(input logic [15:0] len);
    start = 1'b1;
    run_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_vec += 5;
    if (stim_a !== 4'h0) begin n_err++; $display("FAIL reset_stim got %h exp 0", stim_a); end
    if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done_a); end
    if (pass_a !== 1'b0) begin n_err++; $display("FAIL reset_pass got %b exp 0", pass_a); end
    if (err_a !== 16'h0) begin n_err++; $display("FAIL reset_err got %h exp 0", err_a); end
    rst = 1'b0;
    tick();
  endtask

  // Cycle-by-cycle profile of a 4-pattern loopback run on instance a, from cycle c0 on.
  task automatic check_run4(input string tag, input int c0);
    logic [3:0] es;
    for (int c = c0; c <= 6; c++) begin
      es = 4'h0;
      if (c <= 4) es = exp_pat[c-1];
      n_vec += 3;
      if (stim_a !== es) begin n_err++; $display("FAIL %s_stim c=%0d got %h exp %h", tag, c, stim_a, es); end
      if (busy_a !== (c <= 5)) begin n_err++; $display("FAIL %s_busy c=%0d got %b exp %b", tag, c, busy_a, c <= 5); end
      if (done_a !== (c >= 6)) begin n_err++; $display("FAIL %s_done c=%0d got %b exp %b", tag, c, done_a, c >= 6); end
      if (c < 6) tick();
    end
    n_vec += 2;
    if (pass_a !== 1'b1) begin n_err++; $display("FAIL %s_pass got %b exp 1", tag, pass_a); end
    if (err_a !== 16'h0) begin n_err++; $display("FAIL %s_err got %h exp 0", tag, err_a); end
  endtask

  task automatic test_loopback();
    launch(16'd4);
    check_run4("loop", 1);
  endtask

  task automatic test_force_bit();
    force_b2 = 1'b1;
    launch(16'd4);
    n_vec += 1;
    if (done_a !== 1'b0) begin n_err++; $display("FAIL restart_done got %b exp 0", done_a); end
    for (int i = 0; i < 4; i++) tick();
    n_vec += 1;
    if (err_a !== 16'h0) begin n_err++; $display("FAIL force_err_c5 got %h exp 0", err_a); end
    tick();
    n_vec += 3;
    if (done_a !== 1'b1) begin n_err++; $display("FAIL force_done got %b exp 1", done_a); end
    if (err_a !== 16'h1) begin n_err++; $display("FAIL force_err got %h exp 1", err_a); end
    if (pass_a !== 1'b0) begin n_err++; $display("FAIL force_pass got %b exp 0", pass_a); end
    force_b2 = 1'b0;
  endtask

  task automatic test_zero_len();
    launch(16'd0);
    for (int c = 1; c <= 3; c++) begin
      n_vec += 5;
      if (done_a !== 1'b1) begin n_err++; $display("FAIL zero_done c=%0d got %b exp 1", c, done_a); end
      if (pass_a !== 1'b1) begin n_err++; $display("FAIL zero_pass c=%0d got %b exp 1", c, pass_a); end
      if (busy_a !== 1'b0) begin n_err++; $display("FAIL zero_busy c=%0d got %b exp 0", c, busy_a); end
      if (stim_a !== 4'h0) begin n_err++; $display("FAIL zero_stim c=%0d got %h exp 0", c, stim_a); end
      if (err_a !== 16'h0) begin n_err++; $display("FAIL zero_err c=%0d got %h exp 0", c, err_a); end
      tick();
    end
  endtask

  task automatic test_saturate();
    int cyc;
    launch(16'd10);
    cyc = 1;
    while (done_s !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    n_vec += 3;
    if (cyc !== 12) begin n_err++; $display("FAIL sat_done_cycle got %0d exp 12", cyc); end
    if (err_s !== 2'd3) begin n_err++; $display("FAIL sat_err got %0d exp 3", err_s); end
    if (pass_s !== 1'b0) begin n_err++; $display("FAIL sat_pass got %b exp 0", pass_s); end
    tick();
  endtask

  task automatic test_lat2();
    launch(16'd4);
    for (int c = 1; c <= 7; c++) begin
      n_vec += 2;
      if (done_b !== (c >= 7)) begin n_err++; $display("FAIL lat2_done c=%0d got %b exp %b", c, done_b, c >= 7); end
      if (busy_b !== (c <= 6)) begin n_err++; $display("FAIL lat2_busy c=%0d got %b exp %b", c, busy_b, c <= 6); end
      if (c < 7) tick();
    end
    n_vec += 4;
    if (pass_b !== 1'b1) begin n_err++; $display("FAIL lat2_pass got %b exp 1", pass_b); end
    if (err_b !== 16'h0) begin n_err++; $display("FAIL lat2_err got %h exp 0", err_b); end
    if (pass_c !== 1'b0) begin n_err++; $display("FAIL lat1chain_pass got %b exp 0", pass_c); end
    if (err_c === 16'h0) begin n_err++; $display("FAIL lat1chain_err got %h exp nonzero", err_c); end
  endtask

  task automatic test_start_ignored();
    launch(16'd4);
    tick();
    start = 1'b1;
    run_len = 16'd7;
    tick();
    start = 1'b0;
    check_run4("ign", 3);
  endtask

  task automatic test_reset_mid();
    launch(16'd4);
    tick(); tick();
    rst = 1'b1;
    #1;
    n_vec += 5;
    if (stim_a !== 4'h0) begin n_err++; $display("FAIL rmid_stim got %h exp 0", stim_a); end
    if (busy_a !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b exp 0", busy_a); end
    if (done_a !== 1'b0) begin n_err++; $display("FAIL rmid_done got %b exp 0", done_a); end
    if (pass_a !== 1'b0) begin n_err++; $display("FAIL rmid_pass got %b exp 0", pass_a); end
    if (err_a !== 16'h0) begin n_err++; $display("FAIL rmid_err got %h exp 0", err_a); end
    tick();
    rst = 1'b0;
    tick();
    n_vec += 1;
    if (done_a !== 1'b0) begin n_err++; $display("FAIL rmid_idle_done got %b exp 0", done_a); end
    launch(16'd4);
    check_run4("rerun", 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; run_len = 16'd0; force_b2 = 1'b0;
    #2;
    test_reset();
    test_loopback();
    test_force_bit();
    test_zero_len();
    test_saturate();
    test_lat2();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
